// File: rtl/alu_seq_if.sv
// alu_seq_if: bundles every non-clock/reset signal of the ALU sequencer.
//   in_*     upstream operation handshake (valid/ready, operands, opcode)
//   alu_*    registered operands/opcode to the ALU and its results back
//   out_*    downstream result handshake plus status flags
//   op_count completed output handshakes (wraps modulo 2^CNT_W)
// slave  = sequencer view, master = environment (upstream/ALU/downstream) view.
interface alu_seq_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic [3:0]       in_sel;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [3:0]       alu_y;
  logic [7:0]       alu_x;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_res;
  logic             out_zero;
  logic             out_err;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_y, alu_x, out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
    output out_valid, out_res, out_zero, out_err, op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_y, alu_x, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
    input  out_valid, out_res, out_zero, out_err, op_count
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: operation sequencer in front of the combinational 4-bit ALU.
// Accepts one op at a time, registers operands/opcode to the ALU, waits one
// EXEC cycle for the ALU to settle, captures a normalised 8-bit result with
// zero/error flags and holds it until downstream takes it.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_seq_if.slave (upstream, ALU and downstream handshakes, op_count)
module alu_seq #(
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  state_t     state;
  logic       accept;
  logic [7:0] nres;
  logic       nerr;

  // A new op may enter while the previous result leaves in the same cycle,
  // so ready depends combinationally on out_ready.
  assign bus.in_ready = (state == IDLE) | ((state == OUT) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  // Normalisation keyed on the registered opcode; unsupported opcodes and
  // divide-by-zero discard whatever the ALU produced.
  always_comb begin
    nres = {4'b0000, bus.alu_y};
    nerr = 1'b0;
    case (bus.alu_sel)
      4'b0010: nres = bus.alu_x;
      4'b0011: if (bus.alu_b == 4'd0) begin
        nres = 8'h00;
        nerr = 1'b1;
      end
      4'b0100, 4'b0101, 4'b0111: begin
        nres = 8'h00;
        nerr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.alu_a     <= 4'h0;
      bus.alu_b     <= 4'h0;
      bus.alu_sel   <= 4'h0;
      bus.out_res   <= 8'h00;
      bus.out_zero  <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.op_count  <= '0;
    end else begin
      if (accept) begin
        bus.alu_a   <= bus.in_a;
        bus.alu_b   <= bus.in_b;
        bus.alu_sel <= bus.in_sel;
      end
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          bus.out_res   <= nres;
          bus.out_err   <= nerr;
          bus.out_zero  <= (nres == 8'h00) & ~nerr;
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: if (bus.out_ready) begin
          bus.op_count  <= bus.op_count + 1'b1;
          bus.out_valid <= 1'b0;
          state         <= accept ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  typedef struct packed {
    logic [7:0] res;
    logic       zero;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.CNT_W(8)) bus ();
  alu_seq #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ALU model: unsupported codes return junk so ignoring it is observable.
  always_comb begin
    bus.alu_x = bus.alu_a * bus.alu_b;
    case (bus.alu_sel)
      4'b0000: bus.alu_y = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_y = bus.alu_a - bus.alu_b;
      4'b0010: bus.alu_y = bus.alu_x[3:0];
      4'b0011: bus.alu_y = (bus.alu_b != 4'd0) ? bus.alu_a / bus.alu_b : 4'hF;
      4'b0100, 4'b0101, 4'b0111: bus.alu_y = 4'hA;
      4'b0110: bus.alu_y = bus.alu_a & bus.alu_b;
      default: bus.alu_y = bus.alu_a ^ bus.alu_b;
    endcase
  end

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt = 8'h00;
  int         cyc = 0;
  int         last_hs = -1;
  bit         tput_on = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head,
  // pops on handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        chk("out_res", {24'h0, bus.out_res}, {24'h0, sb[0].res});
        chk("out_zero", {31'h0, bus.out_zero}, {31'h0, sb[0].zero});
        chk("out_err", {31'h0, bus.out_err}, {31'h0, sb[0].err});
        if (bus.out_ready) begin
          chk("op_count", {24'h0, bus.op_count}, {24'h0, exp_cnt});
          exp_cnt++;
          if (tput_on && last_hs >= 0) chk("throughput", cyc - last_hs, 32'd2);
          last_hs = cyc;
          void'(sb.pop_front());
        end else begin
          chk("in_ready_bp", {31'h0, bus.in_ready}, 32'd0);
        end
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                      input logic [7:0] res, input logic err);
    int n;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else begin
      e.res  = res;
      e.err  = err;
      e.zero = (res == 8'h00) && !err;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  logic [3:0] st_a  [10] = '{4'd1, 4'd2, 4'd4, 4'd15, 4'd15, 4'd3, 4'd8, 4'd0, 4'd9, 4'd6};
  logic [3:0] st_b  [10] = '{4'd2, 4'd5, 4'd4, 4'd4,  4'd5,  4'd3, 4'd8, 4'd7, 4'd6, 4'd0};
  logic [3:0] st_s  [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                             4'b0100, 4'b0000, 4'b0010, 4'b1111, 4'b0011};
  logic [7:0] st_r  [10] = '{8'h03, 8'h0D, 8'h10, 8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
  logic       st_e  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 4'h0;
    bus.in_b      = 4'h0;
    bus.in_sel    = 4'h0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_out_res", {24'h0, bus.out_res}, 32'd0);
    chk("rst_alu_sel", {28'h0, bus.alu_sel}, 32'd0);
    chk("rst_op_count", {24'h0, bus.op_count}, 32'd0);
    rst = 1'b0;

    // Directed single ops
    send(4'd3, 4'd4, 4'b0000, 8'h07, 1'b0);
    idle();
    drain();
    @(posedge clk); #1;
    chk("op_count_after_first", {24'h0, bus.op_count}, 32'd1);
    send(4'd15, 4'd15, 4'b0010, 8'hE1, 1'b0);
    send(4'd5,  4'd5,  4'b0001, 8'h00, 1'b0);
    send(4'd9,  4'd0,  4'b0011, 8'h00, 1'b1);
    send(4'd9,  4'd0,  4'b0101, 8'h00, 1'b1);
    send(4'd9,  4'd2,  4'b0011, 8'h04, 1'b0);
    send(4'd12, 4'd10, 4'b0110, 8'h08, 1'b0);
    send(4'd5,  4'd3,  4'b1000, 8'h06, 1'b0);
    send(4'd1,  4'd1,  4'b0111, 8'h00, 1'b1);
    send(4'd3,  4'd0,  4'b0010, 8'h00, 1'b0);
    idle();
    drain();

    // Backpressure: next op waits behind a stalled result
    bus.out_ready = 1'b0;
    send(4'd6, 4'd7, 4'b0000, 8'h0D, 1'b0);
    fork
      send(4'd2, 4'd3, 4'b0010, 8'h06, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_gap_low", {31'h0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_gap_high", {31'h0, bus.out_valid}, 32'd1);
    drain();

    // Streaming at full rate
    last_hs = -1;
    tput_on = 1'b1;
    for (int i = 0; i < 10; i++) send(st_a[i], st_b[i], st_s[i], st_r[i], st_e[i]);
    idle();
    drain();
    tput_on = 1'b0;

    // Push op_count through its 255 -> 0 wrap
    for (int i = 0; i < 240; i++) send(4'(i), 4'd0, 4'b0000, {4'h0, 4'(i)}, 1'b0);
    idle();
    drain();
    @(posedge clk); #1;
    chk("op_count_wrapped", {24'h0, bus.op_count}, {24'h0, exp_cnt});

    // Asynchronous reset in the middle of EXEC
    send(4'd1, 4'd1, 4'b0000, 8'h02, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("arst_alu_a", {28'h0, bus.alu_a}, 32'd0);
    chk("arst_alu_sel", {28'h0, bus.alu_sel}, 32'd0);
    chk("arst_op_count", {24'h0, bus.op_count}, 32'd0);
    chk("arst_out_res", {24'h0, bus.out_res}, 32'd0);
    sb.delete();
    exp_cnt = 8'h00;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_out", {31'h0, bus.out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
